// File: rtl/bus_timer_if.sv
// naive_bus: SoC bus with independent read and write channels, 32-bit word
// data and per-byte write enables. Slaves grant requests; read data is
// returned by the slave on the cycle after the request.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled 32-bit timer with compare match,
// optional auto-reload, sticky W1C match/overflow flags and a registered
// level interrupt output. Zero-wait-state naive_bus slave.
module bus_timer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic    clk,
  input  logic    rst,
  naive_bus.slave bus,
  output logic    o_irq
);

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_PRESC   = 3'd1,
    REG_COUNT   = 3'd2,
    REG_COMPARE = 3'd3,
    REG_STATUS  = 3'd4
  } reg_e;

  logic               en;
  logic               auto_reload;
  logic               irq_en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   compare;
  logic               match;
  logic               ovf;

  reg_e               wr_sel;
  reg_e               rd_sel;
  logic               wr_ctrl;
  logic               wr_presc;
  logic               wr_count;
  logic               wr_compare;
  logic               wr_status;
  logic [PRESC_W-1:0] presc_wr;
  logic [CNT_W-1:0]   count_wr;
  logic [CNT_W-1:0]   compare_wr;
  logic               clr_match;
  logic               clr_ovf;
  logic               tick;
  logic               hit;
  logic               wrap;
  logic [31:0]        rd_val;
  logic               addr_unused;

  // Always-ready handshake; address bits outside the register field are don't-care.
  always_comb begin
    bus.rd_gnt  = bus.rd_req;
    bus.wr_gnt  = bus.wr_req;
    addr_unused = ^{bus.rd_addr[31:5], bus.rd_addr[1:0],
                    bus.wr_addr[31:5], bus.wr_addr[1:0]};
  end

  // Write decode, byte-lane merge, W1C qualification and tick/match/wrap events.
  always_comb begin
    wr_sel     = reg_e'(bus.wr_addr[4:2]);
    wr_ctrl    = bus.wr_req && (wr_sel == REG_CTRL);
    wr_presc   = bus.wr_req && (wr_sel == REG_PRESC);
    wr_count   = bus.wr_req && (wr_sel == REG_COUNT);
    wr_compare = bus.wr_req && (wr_sel == REG_COMPARE);
    wr_status  = bus.wr_req && (wr_sel == REG_STATUS);
    presc_wr   = presc;
    count_wr   = count;
    compare_wr = compare;
    for (int unsigned i = 0; i < PRESC_W / 8; i++) begin
      if (bus.wr_be[i]) presc_wr[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
    for (int unsigned i = 0; i < CNT_W / 8; i++) begin
      if (bus.wr_be[i]) begin
        count_wr[8*i +: 8]   = bus.wr_data[8*i +: 8];
        compare_wr[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
    clr_match = wr_status && bus.wr_be[0] && bus.wr_data[0];
    clr_ovf   = wr_status && bus.wr_be[0] && bus.wr_data[1];
    tick      = en && (pcnt == presc);
    hit       = tick && (count == compare);
    wrap      = tick && !hit && (&count);
  end

  // Read mux over the pre-edge register state.
  always_comb begin
    rd_sel = reg_e'(bus.rd_addr[4:2]);
    rd_val = '0;
    case (rd_sel)
      REG_CTRL:    rd_val[2:0]         = {irq_en, auto_reload, en};
      REG_PRESC:   rd_val[PRESC_W-1:0] = presc;
      REG_COUNT:   rd_val[CNT_W-1:0]   = count;
      REG_COMPARE: rd_val[CNT_W-1:0]   = compare;
      REG_STATUS:  rd_val[1:0]         = {ovf, match};
      default:     rd_val              = '0;
    endcase
  end

  // Software-owned configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      presc       <= '0;
      compare     <= '1;
    end else begin
      if (wr_ctrl && bus.wr_be[0]) {irq_en, auto_reload, en} <= bus.wr_data[2:0];
      if (wr_presc)   presc   <= presc_wr;
      if (wr_compare) compare <= compare_wr;
    end
  end

  // Prescaler: restarts on any CTRL/PRESC write, wraps on reaching presc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wr_ctrl || wr_presc || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Counter and sticky flags; software COUNT write beats a tick, hardware set beats W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      match <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= count_wr;
      end else if (hit && auto_reload) begin
        count <= '0;
      end else if (tick) begin
        count <= count + 1'b1;
      end
      match <= hit  | (match & ~clr_match);
      ovf   <= wrap | (ovf & ~clr_ovf);
    end
  end

  // Registered read data (held between reads) and interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
      o_irq       <= 1'b0;
    end else begin
      if (bus.rd_req) bus.rd_data <= rd_val;
      o_irq <= match & irq_en;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed scenarios with hand-derived expectations,
// then randomized bus traffic checked cycle by cycle against a behavioural
// model of the timer's register-level rules.
module tb_bus_timer;

  localparam logic [31:0] BASE      = 32'h0003_2000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h00;
  localparam logic [31:0] A_PRESC   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT   = BASE + 32'h08;
  localparam logic [31:0] A_COMPARE = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS  = BASE + 32'h10;
  localparam logic [31:0] A_UNUSED  = BASE + 32'h18;

  logic clk = 1'b0;
  logic rst;
  logic o_irq;
  int   n_tests = 0;
  int   n_fail  = 0;

  naive_bus bus_if ();

  bus_timer #(.CNT_W(32), .PRESC_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .o_irq (o_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: register file plus "clocks elapsed in this prescale period".
  logic [2:0]  m_ctrl;     // {irq_en, auto_reload, en}
  logic [15:0] m_presc;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_match;
  logic        m_ovf;
  int unsigned m_phase;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [2:0] off;
    off = a[4:2];
    case (off)
      3'd0:    return {29'b0, m_ctrl};
      3'd1:    return {16'b0, m_presc};
      3'd2:    return m_count;
      3'd3:    return m_compare;
      3'd4:    return {30'b0, m_ovf, m_match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'b0; m_presc = 16'h0; m_count = 32'h0; m_compare = 32'hFFFF_FFFF;
    m_match = 1'b0; m_ovf = 1'b0; m_phase = 0; m_rd = 32'h0; m_irq = 1'b0;
  endtask

  // Advance the model by one clock edge given the bus activity of that cycle.
  task automatic model_step(input logic rd, input logic [31:0] ra, input logic wr,
                            input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic        period_end;
    logic        set_m;
    logic        set_o;
    logic [31:0] old_count;
    logic [31:0] tmp;
    logic [2:0]  off;
    old_count  = m_count;
    if (rd) m_rd = model_read(ra);
    m_irq      = m_match & m_ctrl[2];
    period_end = m_ctrl[0] && (m_phase == 32'(m_presc));
    set_m = 1'b0;
    set_o = 1'b0;
    if (period_end) begin
      if (old_count == m_compare) begin
        set_m   = 1'b1;
        m_count = m_ctrl[1] ? 32'h0 : old_count + 32'd1;
      end else begin
        m_count = old_count + 32'd1;
        set_o   = (old_count == 32'hFFFF_FFFF);
      end
    end
    if (m_ctrl[0]) m_phase = period_end ? 0 : m_phase + 1;
    if (wr) begin
      off = wa[4:2];
      case (off)
        3'd0: begin if (be[0]) m_ctrl = wd[2:0]; m_phase = 0; end
        3'd1: begin tmp = merge({16'h0, m_presc}, wd, be); m_presc = tmp[15:0]; m_phase = 0; end
        3'd2: m_count = merge(old_count, wd, be);
        3'd3: m_compare = merge(m_compare, wd, be);
        3'd4: if (be[0]) begin
                if (wd[0]) m_match = 1'b0;
                if (wd[1]) m_ovf = 1'b0;
              end
        default: ;
      endcase
    end
    if (set_m) m_match = 1'b1;
    if (set_o) m_ovf = 1'b1;
  endtask

  // One bus cycle: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input logic rd, input logic [31:0] ra, input logic wr,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    bus_if.rd_req  = rd;
    bus_if.rd_addr = ra;
    bus_if.wr_req  = wr;
    bus_if.wr_addr = wa;
    bus_if.wr_data = wd;
    bus_if.wr_be   = be;
    #1;
    check("rd_gnt", 32'(bus_if.rd_gnt), 32'(rd));
    check("wr_gnt", 32'(bus_if.wr_gnt), 32'(wr));
    @(posedge clk);
    model_step(rd, ra, wr, wa, wd, be);
    @(negedge clk);
    check("rd_data", bus_if.rd_data, m_rd);
    check("o_irq", 32'(o_irq), 32'(m_irq));
    bus_if.rd_req = 1'b0;
    bus_if.wr_req = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle(1'b0, 32'h0, 1'b1, a, d, be);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] d);
    cycle(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    d = bus_if.rd_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_rd_data", bus_if.rd_data, 32'h0);
    check("rst_irq", 32'(o_irq), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values();
    logic [31:0] v;
    rd32(A_CTRL, v);    check("reset_ctrl", v, 32'h0);
    rd32(A_PRESC, v);   check("reset_presc", v, 32'h0);
    rd32(A_COUNT, v);   check("reset_count", v, 32'h0);
    rd32(A_COMPARE, v); check("reset_compare", v, 32'hFFFF_FFFF);
    rd32(A_STATUS, v);  check("reset_status", v, 32'h0);
    rd32(A_UNUSED, v);  check("reset_unused", v, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic        rd;
    logic        wr;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
    int unsigned pick;

    rst = 1'b1;
    bus_if.rd_req = 1'b0; bus_if.rd_addr = 32'h0;
    bus_if.wr_req = 1'b0; bus_if.wr_addr = 32'h0;
    bus_if.wr_data = 32'h0; bus_if.wr_be = 4'h0;
    model_reset();
    @(negedge clk);
    check("por_rd_data", bus_if.rd_data, 32'h0);
    check("por_irq", 32'(o_irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // Prescaled count: 50 clocks at presc=4 gives 10 ticks, then freeze.
    do_reset();
    wr32(A_PRESC, 32'd4, 4'hF);
    wr32(A_CTRL, 32'd1, 4'hF);
    idle(50);
    rd32(A_COUNT, v);   check("presc_count", v, 32'd10);
    wr32(A_CTRL, 32'd0, 4'hF);
    idle(10);
    rd32(A_COUNT, v);   check("freeze_count", v, 32'd10);
    rd32(A_PRESC, v);   check("presc_readback", v, 32'd4);

    // Auto-reload with interrupt: COUNT 0..9,0..9; o_irq rises one edge after match.
    do_reset();
    wr32(A_PRESC, 32'd0, 4'hF);
    wr32(A_COMPARE, 32'd9, 4'hF);
    wr32(A_CTRL, 32'd7, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      rd32(A_COUNT, v);
      check("ar_count", v, 32'((k - 1) % 10));
      check("ar_irq", 32'(o_irq), (k >= 11) ? 32'd1 : 32'd0);
    end
    rd32(A_STATUS, v);  check("ar_status", v, 32'd1);
    wr32(A_CTRL, 32'd6, 4'hF);
    wr32(A_STATUS, 32'd1, 4'h1);
    check("irq_before_clear", 32'(o_irq), 32'd1);
    idle(1);
    check("irq_after_clear", 32'(o_irq), 32'd0);
    rd32(A_STATUS, v);  check("status_cleared", v, 32'd0);

    // Reset while counting with the interrupt asserted.
    do_reset();
    wr32(A_COMPARE, 32'd2, 4'hF);
    wr32(A_CTRL, 32'd7, 4'hF);
    idle(8);
    check("irq_pre_reset", 32'(o_irq), 32'd1);
    do_reset();
    check_reset_values();

    // Overflow: two ticks from 0xFFFF_FFFE wrap to 0 and set ovf only.
    do_reset();
    wr32(A_COMPARE, 32'd5, 4'hF);
    wr32(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr32(A_CTRL, 32'd1, 4'hF);
    idle(1);
    wr32(A_CTRL, 32'd0, 4'hF);
    rd32(A_COUNT, v);   check("ovf_count", v, 32'd0);
    rd32(A_STATUS, v);  check("ovf_status", v, 32'd2);

    // Collision: COUNT write on a tick edge wins.
    do_reset();
    wr32(A_PRESC, 32'd3, 4'hF);
    wr32(A_CTRL, 32'd1, 4'hF);
    idle(3);
    wr32(A_COUNT, 32'h100, 4'hF);
    wr32(A_CTRL, 32'd0, 4'hF);
    rd32(A_COUNT, v);   check("coll_count", v, 32'h100);

    // Collision: W1C of match on the edge that sets it leaves it set.
    do_reset();
    wr32(A_PRESC, 32'd3, 4'hF);
    wr32(A_COMPARE, 32'd5, 4'hF);
    wr32(A_COUNT, 32'd5, 4'hF);
    wr32(A_CTRL, 32'd1, 4'hF);
    idle(3);
    wr32(A_STATUS, 32'd1, 4'h1);
    wr32(A_CTRL, 32'd0, 4'hF);
    rd32(A_STATUS, v);  check("coll_match", v, 32'd1);
    rd32(A_COUNT, v);   check("coll_match_count", v, 32'd6);

    // Byte enables and unused space.
    do_reset();
    wr32(A_COMPARE, 32'hAABB_CCDD, 4'b0010);
    rd32(A_COMPARE, v); check("be_compare", v, 32'hFFFF_CCFF);
    wr32(A_UNUSED, 32'hFFFF_FFFF, 4'hF);
    rd32(A_UNUSED, v);  check("unused_read", v, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rd   = ($urandom_range(0, 99) < 40);
      ra   = $urandom;
      wr   = ($urandom_range(0, 99) < 30);
      be   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      pick = $urandom_range(0, 9);
      wd   = $urandom;
      case (pick)
        0, 1: begin
          wa = A_CTRL;
          wd = {29'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
        end
        2: begin wa = A_PRESC; wd = $urandom_range(0, 3); end
        3, 4: begin
          wa = A_COUNT;
          wd = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20)
                                           : 32'hFFFF_FFF0 + $urandom_range(0, 15);
        end
        5: begin wa = A_COMPARE; wd = $urandom_range(0, 20); end
        6, 7: begin wa = A_STATUS; wd = $urandom_range(0, 3); end
        8: wa = BASE + 32'h14 + 32'(4 * $urandom_range(0, 2));
        default: wa = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) wa = {27'($urandom), wa[4:2], 2'($urandom)};
      cycle(rd, ra, wr, wa, wd, be);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped 32-bit timer/compare peripheral on the SoC `naive_bus`, added as slave 6 of the router at 0x0003_2000–0x0003_201f. Core data master and UART debugger program it with word accesses. It provides:
- a prescaled free-running or auto-reload counter;
- a compare match flag, sticky until software clears it (write-1-to-clear);
- a level `o_irq` output for LED/debug wiring and future interrupt use.

## Interface
- `CNT_W`, 32, counter/compare width; fixed at 32 for this SoC.
- `PRESC_W`, 16, prescaler width.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `bus`  naive_bus slave modport: `rd_req`/`rd_gnt`/`rd_addr[31:0]`/`rd_data[31:0]`, `wr_req`/`wr_gnt`/`wr_addr[31:0]`/`wr_data[31:0]`/`wr_be[3:0]`.
- `o_irq`  out  1  `STATUS.match & CTRL.irq_en`, registered.

## Operation
- Register decode uses `addr[4:2]`; all other address bits are ignored.
- Register map (offset, reset value):
  - 0x00 CTRL, 0: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`; other bits read 0.
  - 0x04 PRESC, 0: bits[15:0] `presc`; tick period is `presc+1` clocks.
  - 0x08 COUNT, 0: current count, writable.
  - 0x0C COMPARE, 0xFFFF_FFFF.
  - 0x10 STATUS, 0: bit0 `match` (W1C); bit1 `ovf` (W1C), set on wrap 0xFFFF_FFFF→0.
  - 0x14–0x1C: reads return 0; writes are ignored.
- Prescaler:
  - `pcnt` increments each clock while `en`=1.
  - When `pcnt==presc`, `pcnt`←0 and `tick`=1 for one cycle.
  - `en`=0 holds both `pcnt` and COUNT.
  - Any write to PRESC or CTRL clears `pcnt`.
- On tick:
  - If `COUNT==COMPARE`: `match`←1. If `auto_reload`=1, COUNT←0; otherwise COUNT←COUNT+1.
  - Else COUNT←COUNT+1 mod 2^32; `ovf`←1 on wrap.
- Byte enables:
  - Writes honour `wr_be` per byte.
  - W1C applies only to bits whose byte lane is enabled.
- Bus slave behaviour:
  - Always ready: `rd_gnt=rd_req` and `wr_gnt=wr_req`, combinational.
  - A write takes effect at the rising edge where `wr_req`=1.
  - `rd_data` is registered, valid the cycle after `rd_req`, and held until the next read.
- Priority rules:
  - A software write to COUNT in the same cycle as a tick wins; no increment that cycle.
  - A hardware set of `match`/`ovf` in the same cycle as a W1C of that bit: set wins, bit stays 1.
  - A read in the same cycle as an update returns the pre-edge value.

## Timing
- Reset is asynchronous. Every register takes the value in the map, plus `pcnt`=0, `rd_data`=0, `o_irq`=0.
- Reset asserted mid-count aborts immediately; there is no partial state.
- Read latency is 1 cycle; the slave has no wait states. Back-to-back reads are supported every cycle.
- With `en` set at edge E and `presc`=0, COUNT updates at E+1, E+2, …
- With `presc`=P, the first tick is at E+P+1 and ticks repeat every P+1 cycles.
- `match` is visible in STATUS reads and the internal flag one cycle after the tick edge.
- `o_irq` follows `match` one cycle later: 2 cycles after the matching tick.
- Auto-reload period is `(COMPARE+1)*(presc+1)` clocks.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-operation, then release it.
  - Required: all registers read back their reset values (COMPARE=0xFFFF_FFFF); `o_irq`=0; `rd_data` valid 1 cycle after `rd_req`.
- Prescaled count:
  - Stimulus: PRESC=4, CTRL=1, run 50 clocks.
  - Required: COUNT=10 ±1 depending on sampling edge (exact value checked against a reference model).
  - Required: disabling `en` freezes COUNT.
- Auto-reload with interrupt:
  - Stimulus: PRESC=0, COMPARE=9, CTRL=0x7.
  - Required: COUNT sequence 0..9,0..9; `match` set at the first 9→0 transition.
  - Required: `o_irq` rises 2 cycles after that tick.
  - Required: writing STATUS=1 clears `match` and `o_irq`.
- Overflow:
  - Stimulus: COUNT=0xFFFF_FFFE, COMPARE=5, `en`=1, `presc`=0.
  - Required: after 2 ticks COUNT=0 and `ovf`=1; `match` stays 0.
- Collisions:
  - Stimulus 1: write COUNT=0x100 on a tick edge. Required: COUNT reads 0x100.
  - Stimulus 2: W1C `match` on the same edge as a new match. Required: `match` reads 1.
- Byte enables and unused space:
  - Stimulus: write COMPARE with `wr_be`=0b0010, data 0xAABB_CCDD.
  - Required: COMPARE=0xFFFF_CCFF.
  - Required: a read of offset 0x18 returns 0.
